// File: rtl/watch_pkg.sv
// Shared types and constants for the watch display path.
// Latency: n/a (declarations only).
// Backpressure: n/a. Contents: mode constants, character codes, char_t record, commit FSM states.
package watch_pkg;

  // Display mode carried with every character.
  localparam logic NUMBER   = 1'b0;
  localparam logic ALPHABET = 1'b1;

  // Character codes used in ALPHABET mode.
  localparam logic [3:0] C_SPACE = 4'd0;
  localparam logic [3:0] C_A     = 4'd1;
  localparam logic [3:0] C_D     = 4'd2;
  localparam logic [3:0] C_E     = 4'd3;
  localparam logic [3:0] C_F     = 4'd4;
  localparam logic [3:0] C_H     = 4'd5;
  localparam logic [3:0] C_I     = 4'd6;
  localparam logic [3:0] C_N     = 4'd7;
  localparam logic [3:0] C_O     = 4'd8;
  localparam logic [3:0] C_P     = 4'd9;
  localparam logic [3:0] C_R     = 4'd10;
  localparam logic [3:0] C_S     = 4'd11;
  localparam logic [3:0] C_T     = 4'd12;
  localparam logic [3:0] C_U     = 4'd13;

  // One displayed character: code plus mode.
  typedef struct packed {
    logic [3:0] value;
    logic       mode;
  } char_t;

  // A blank digit: space in alphabet mode.
  localparam char_t CHAR_BLANK = '{value: C_SPACE, mode: ALPHABET};

  // Shadow-to-active commit handshake states.
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } commit_state_e;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Bundle between the watch controller (master) and the display scanner (slave).
// Latency: n/a (wires only).
// Backpressure: none; writes and commit requests are always accepted.
// Signals: wr_en/wr_idx/wr_value/wr_mode, commit_req -> scanner; commit_pending, commit_ack,
//   value, mode, digit_sel, frame_done <- scanner; blink_mask -> scanner only with SEVEN_SEG_BLINK_EN.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 6
);
  logic                  wr_en;
  logic [2:0]            wr_idx;
  logic [3:0]            wr_value;
  logic                  wr_mode;
  logic                  commit_req;
  logic                  commit_pending;
  logic                  commit_ack;
  logic [3:0]            value;
  logic                  mode;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic                  frame_done;
`ifdef SEVEN_SEG_BLINK_EN
  logic [NUM_DIGITS-1:0] blink_mask;
`endif

  modport master (
    output wr_en, wr_idx, wr_value, wr_mode, commit_req,
`ifdef SEVEN_SEG_BLINK_EN
    output blink_mask,
`endif
    input  commit_pending, commit_ack, value, mode, digit_sel, frame_done
  );

  modport slave (
    input  wr_en, wr_idx, wr_value, wr_mode, commit_req,
`ifdef SEVEN_SEG_BLINK_EN
    input  blink_mask,
`endif
    output commit_pending, commit_ack, value, mode, digit_sel, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_timer.sv
// Slot/digit timebase for the display scanner.
// Latency: outputs are combinational decodes of the slot counter and digit index.
// Backpressure: none; free-running. Ports: clk, rst, o_idx (digit index), o_blank, o_frame_done.
module seven_seg_scan_timer #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [$clog2(NUM_DIGITS)-1:0] o_idx,
  output logic                          o_blank,
  output logic                          o_frame_done
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_idx        = r_idx;
  // The first BLANK_CYC cycles of a slot keep every digit dark so the
  // previous digit's segments cannot ghost onto the newly selected one.
  assign o_blank      = (r_cnt < CNT_W'(BLANK_CYC));
  assign o_frame_done = (r_cnt == CNT_MAX) && (r_idx == IDX_MAX);
endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver: shadow/active character buffers, tear-free frame commit, digit scan.
// Latency: value/mode/digit_sel registered one cycle after timer state; commit copies at the next frame boundary.
// Backpressure: none; writes always land in the shadow buffer, repeated commit requests merge into one ack.
// Ports: clk, rst (sync, active-high), bus (seven_seg_scanner_if.slave).
// Optional: SEVEN_SEG_BLINK_EN adds blink_mask and a frame-count blink phase that darkens masked digits.
module seven_seg_scanner
  import watch_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 16,
  parameter int BLINK_DIV  = 32
) (
  input logic               clk,
  input logic               rst,
  seven_seg_scanner_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seven_seg_scanner: NUM_DIGITS must be within 2..8");
  end
  if (SCAN_DIV < BLANK_CYC + 1) begin : g_bad_scan_div
    $error("seven_seg_scanner: SCAN_DIV must exceed BLANK_CYC");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("seven_seg_scanner: BLINK_DIV must be at least 1");
  end

  logic [IDX_W-1:0]      w_idx;
  logic                  w_blank;
  logic                  w_frame_done;
  logic                  w_wr_hit;
  logic                  w_commit_ack;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [NUM_DIGITS-1:0] w_dark;

  char_t                 r_shadow [NUM_DIGITS];
  char_t                 r_active [NUM_DIGITS];
  commit_state_e         r_state;
  commit_state_e         w_next_state;
  logic [3:0]            r_value;
  logic                  r_mode;
  logic [NUM_DIGITS-1:0] r_digit_sel;

  seven_seg_scan_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .o_idx       (w_idx),
    .o_blank     (w_blank),
    .o_frame_done(w_frame_done)
  );

  // Out-of-range indices are dropped silently.
  assign w_wr_hit = bus.wr_en && ({29'd0, bus.wr_idx} < 32'(NUM_DIGITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= CHAR_BLANK;
    end else if (w_wr_hit) begin
      r_shadow[bus.wr_idx[IDX_W-1:0]] <= '{value: bus.wr_value, mode: bus.wr_mode};
    end
  end

  // Non-blocking copy takes the shadow as it was before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_active[i] <= CHAR_BLANK;
    end else if (w_commit_ack) begin
      r_active <= r_shadow;
    end
  end

  // Commit FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Commit FSM: next state. Requests while pending simply merge.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.commit_req) w_next_state = PEND;
      PEND:    if (w_frame_done)   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Commit FSM: outputs.
  always_comb begin
    bus.commit_pending = (r_state == PEND);
    w_commit_ack       = (r_state == PEND) && w_frame_done;
    bus.commit_ack     = w_commit_ack;
  end

`ifdef SEVEN_SEG_BLINK_EN
  localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BC_W-1:0] r_blink_cnt;
  logic            r_blink_off;

  // Phase flips after every BLINK_DIV completed frames; starts in the lit phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (w_frame_done) begin
      if (r_blink_cnt == BC_W'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_dark = r_blink_off ? bus.blink_mask : '0;
`else
  assign w_dark = '0;
`endif

  assign w_onehot = NUM_DIGITS'(1) << w_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value     <= C_SPACE;
      r_mode      <= ALPHABET;
      r_digit_sel <= '0;
    end else begin
      r_value     <= r_active[w_idx].value;
      r_mode      <= r_active[w_idx].mode;
      r_digit_sel <= w_blank ? '0 : (w_onehot & ~w_dark);
    end
  end

  assign bus.value      = r_value;
  assign bus.mode       = r_mode;
  assign bus.digit_sel  = r_digit_sel;
  assign bus.frame_done = w_frame_done;
endmodule
